// File: rtl/niosii_sysid_pkg.sv
// Shared types and constants for the system ID checker.
package niosii_sysid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } sysid_state_e;

  localparam logic        SYSID_ADDR_ID           = 1'b0;
  localparam logic        SYSID_ADDR_TS           = 1'b1;
  localparam int unsigned SYSID_WAIT_W            = 16;
  localparam logic [31:0] SYSID_DEFAULT_ID        = 32'd305419896;
  localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1413884236;
  localparam logic [15:0] SYSID_DEFAULT_TIMEOUT   = 16'd255;

  // True in the states that hold an Avalon read open.
  function automatic logic sysid_is_read(input sysid_state_e s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

endpackage

// File: rtl/niosii_sysid_wait_timer.sv
// Stall counter for one Avalon read: counts waitrequest-high cycles,
// saturates instead of wrapping, and flags when the limit is reached.
// A limit of zero never expires.
module niosii_sysid_wait_timer #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  // Saturating up-count while enabled; clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end
  end

  // Terminal-count compare against the programmed limit.
  always_comb begin
    o_expired = (i_limit != '0) && (r_count >= i_limit);
  end

endmodule

// File: rtl/niosii_sysid_checker.sv
// Boot-time image check: reads the sysid ID and timestamp words over
// Avalon-MM, compares them with build-time constants and reports the
// result for one cycle, holding it until the next accepted start.
//
// state | meaning
// IDLE  | no read open, waiting for start
// RD_ID | read of address 0 (ID word) outstanding
// RD_TS | read of address 1 (timestamp word) outstanding
// DONE  | results valid, done pulse, back to IDLE next cycle
module niosii_sysid_checker
  import niosii_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
  parameter logic [15:0] TIMEOUT_CYCLES     = SYSID_DEFAULT_TIMEOUT
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_start,
  output logic        o_avm_address,
  output logic        o_avm_read,
  input  logic        i_avm_waitrequest,
  input  logic [31:0] i_avm_readdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_id_value,
  output logic [31:0] o_ts_value,
  output logic        o_id_match,
  output logic        o_ts_match,
  output logic        o_timeout,
  output logic        o_pass
);

  sysid_state_e r_state;
  sysid_state_e w_next_state;

  logic        r_avm_read;
  logic        r_avm_address;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout;
  logic        r_pass;

  logic w_in_read;
  logic w_accept;
  logic w_capture_id;
  logic w_capture_ts;
  logic w_expired;
  logic w_timeout_hit;
  logic w_timer_clear;
  logic w_timer_enable;

  assign w_in_read      = sysid_is_read(r_state);
  assign w_accept       = (r_state == IDLE) && i_start;
  assign w_capture_id   = (r_state == RD_ID) && !i_avm_waitrequest;
  assign w_capture_ts   = (r_state == RD_TS) && !i_avm_waitrequest;
  assign w_timeout_hit  = w_in_read && i_avm_waitrequest && w_expired;
  // The stall budget is per read, so restart it between the two words.
  assign w_timer_clear  = !w_in_read || w_capture_id;
  assign w_timer_enable = w_in_read && i_avm_waitrequest;

  niosii_sysid_wait_timer #(
    .W(SYSID_WAIT_W)
  ) u_wait_timer (
    .i_clk    (i_clock),
    .i_rst_n  (i_reset_n),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_enable),
    .i_limit  (TIMEOUT_CYCLES),
    .o_expired(w_expired)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a stalled read that hits the limit abandons the check.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_next_state = RD_ID;
      end
      RD_ID: begin
        if (!i_avm_waitrequest) w_next_state = RD_TS;
        else if (w_expired)     w_next_state = DONE;
      end
      RD_TS: begin
        if (!i_avm_waitrequest || w_expired) w_next_state = DONE;
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Bus strobes are registered off the next state so they change only on edges.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_avm_read    <= 1'b0;
      r_avm_address <= SYSID_ADDR_ID;
    end else begin
      r_avm_read    <= sysid_is_read(w_next_state);
      r_avm_address <= (w_next_state == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end
  end

  // Result capture; cleared by an accepted start, otherwise held.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_pass     <= 1'b0;
    end else if (w_accept) begin
      r_id_value <= '0;
      r_ts_value <= '0;
      r_id_match <= 1'b0;
      r_ts_match <= 1'b0;
      r_timeout  <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      if (w_capture_id) begin
        r_id_value <= i_avm_readdata;
        r_id_match <= (i_avm_readdata == EXPECTED_ID);
      end
      if (w_capture_ts) begin
        r_ts_value <= i_avm_readdata;
        r_ts_match <= (i_avm_readdata == EXPECTED_TIMESTAMP);
        r_pass     <= r_id_match && (i_avm_readdata == EXPECTED_TIMESTAMP);
      end
      if (w_timeout_hit) begin
        r_timeout <= 1'b1;
        r_pass    <= 1'b0;
      end
    end
  end

  // Output decode.
  always_comb begin
    o_busy        = (r_state != IDLE);
    o_done        = (r_state == DONE);
    o_avm_read    = r_avm_read;
    o_avm_address = r_avm_address;
    o_id_value    = r_id_value;
    o_ts_value    = r_ts_value;
    o_id_match    = r_id_match;
    o_ts_match    = r_ts_match;
    o_timeout     = r_timeout;
    o_pass        = r_pass;
  end

endmodule
